// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam int unsigned FRAME_DATA_BITS = 8;
   localparam int unsigned BIT_CNT_W       = 4;
   localparam logic        START_BIT       = 1'b0;
   localparam logic        STOP_BIT        = 1'b1;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus glitch filter for one PS/2 line.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   line       : asynchronous PS/2 line (idle high)
//   filt       : filtered line; changes only after FILTER_LEN equal
//                consecutive samples that differ from its current value
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic line,
   output logic filt
);

   localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

   logic             sync_1;
   logic             sync_2;
   logic [CNT_W-1:0] cnt;

   // Synchronize, then count consecutive samples that disagree with filt.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         filt   <= 1'b1;
         cnt    <= '0;
      end else begin
         sync_1 <= line;
         sync_2 <= sync_1;
         if (sync_2 != filt) begin
            if (cnt == CNT_W'(FILTER_LEN - 1)) begin
               filt <= sync_2;
               cnt  <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   ps2_clk    : asynchronous PS/2 clock line (idle high)
//   ps2_data   : asynchronous PS/2 data line (idle high)
//   data       : last correctly received byte
//   valid      : one-cycle pulse, data holds a new byte
//   error      : one-cycle pulse, a frame was discarded (parity/stop/timeout)
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 8,
   parameter int unsigned TIMEOUT    = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data,
   output logic       valid,
   output logic       error
);

   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

   logic f_clk;
   logic f_data;
   logic f_clk_q;
   logic armed_q;
   logic fall;

   ps2_state_t           state_q, state_d;
   logic [7:0]           shift_q, shift_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                 par_q, par_d;
   logic [TO_W-1:0]      to_q, to_d;
   logic [7:0]           data_d;
   logic                 valid_d;
   logic                 error_d;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk   (clk),
      .reset (reset),
      .line  (ps2_clk),
      .filt  (f_clk)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .clk   (clk),
      .reset (reset),
      .line  (ps2_data),
      .filt  (f_data)
   );

   // Edges only count once the filtered clock has been observed high after reset.
   assign fall = armed_q & f_clk_q & ~f_clk;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         par_q     <= 1'b0;
         to_q      <= '0;
         data      <= 8'h00;
         valid     <= 1'b0;
         error     <= 1'b0;
         f_clk_q   <= 1'b1;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         par_q     <= par_d;
         to_q      <= to_d;
         data      <= data_d;
         valid     <= valid_d;
         error     <= error_d;
         f_clk_q   <= f_clk;
         armed_q   <= armed_q | f_clk;
      end
   end

   // Next-state, frame assembly and timeout.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      par_d     = par_q;
      to_d      = to_q;
      data_d    = data;
      valid_d   = 1'b0;
      error_d   = 1'b0;

      case (state_q)
         IDLE: begin
            to_d = '0;
            if (fall && (f_data == START_BIT)) begin
               state_d   = DATA;
               bit_cnt_d = '0;
               par_d     = 1'b0;
            end
         end
         DATA: begin
            if (fall) begin
               shift_d   = {f_data, shift_q[7:1]};
               par_d     = par_q ^ f_data;
               bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               if (bit_cnt_q == BIT_CNT_W'(FRAME_DATA_BITS - 1)) begin
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (fall) begin
               par_d   = par_q ^ f_data;
               state_d = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               state_d = IDLE;
               if (par_q && (f_data == STOP_BIT)) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Inside a frame: edges clear the watchdog and take priority over expiry.
      if (state_q != IDLE) begin
         if (fall) begin
            to_d = '0;
         end else if (to_q == TO_W'(TIMEOUT - 1)) begin
            to_d    = '0;
            state_d = IDLE;
            error_d = 1'b1;
         end else begin
            to_d = to_q + TO_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ps2_rx.sv
// Randomized scoreboard bench for ps2_rx.
module tb_ps2_rx;

   localparam int unsigned FLEN = 8;
   localparam int unsigned TOUT = 1000;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       ps2_clk  = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       error;

   typedef struct {
      logic       is_err;
      logic [7:0] data;
      longint     cyc;     // -1: arrival cycle not checked
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         total = 0;
   int         bad = 0;
   longint     cyc = 0;
   longint     last_fall_cyc = 0;
   int         half = 16;
   logic [7:0] last_good = 8'h00;
   logic       prev_valid = 1'b0;

   ps2_rx #(.FILTER_LEN(FLEN), .TIMEOUT(TOUT)) dut (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .data     (data),
      .valid    (valid),
      .error    (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Parity bit that makes the 9-bit total odd.
   function automatic logic odd_par(input logic [7:0] b);
      return ~(^b);
   endfunction

   // Drive the first nbits bits of a frame; data changes while ps2_clk is high.
   task automatic send_bits(input logic [7:0] b, input logic par, input logic stop, input int nbits);
      logic [10:0] fr;
      fr = {stop, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         wait_cyc(half);
         ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         wait_cyc(half);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   // mode 0: good frame, 1: wrong parity, 2: stop bit 0.
   task automatic send_frame(input logic [7:0] b, input int mode);
      exp_t e;
      logic par;
      logic stop;
      par  = odd_par(b) ^ (mode == 1);
      stop = (mode != 2);
      if (mode == 0) begin
         e = '{1'b0, b, -1};
         last_good = b;
      end else begin
         e = '{1'b1, last_good, -1};
      end
      sb.push_back(e);
      send_bits(b, par, stop, 11);
   endtask

   // Monitor: every valid/error pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (valid || error) begin
         total++;
         if (valid && error) begin
            bad++;
            $display("FAIL both_high valid=%0d error=%0d", valid, error);
         end else if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event valid=%0d error=%0d data=%h cyc=%0d", valid, error, data, cyc);
         end else begin
            mon_e = sb.pop_front();
            if ((mon_e.is_err !== error) || (data !== mon_e.data) ||
                ((mon_e.cyc >= 0) && (cyc != mon_e.cyc))) begin
               bad++;
               $display("FAIL event got err=%0d data=%h cyc=%0d expected err=%0d data=%h cyc=%0d",
                        error, data, cyc, mon_e.is_err, mon_e.data, mon_e.cyc);
            end
         end
      end
      if (valid) begin
         total++;
         if (prev_valid) begin
            bad++;
            $display("FAIL valid_width got=2+ cycles expected=1 cycle at cyc=%0d", cyc);
         end
      end
      prev_valid = valid;
   end

   initial begin
      logic [7:0] b;
      int         r;

      wait_cyc(5);
      check("reset_data", 32'(data), 32'h00);
      check("reset_valid", 32'(valid), 32'h0);
      check("reset_error", 32'(error), 32'h0);
      reset = 1'b0;
      wait_cyc(20);

      // Single good frame, then back-to-back burst.
      send_frame(8'h1C, 0);
      send_frame(8'hE0, 0);
      send_frame(8'hF0, 0);
      send_frame(8'h1C, 0);

      // Bad parity, then bad stop bit.
      send_frame(8'h1C, 1);
      send_frame(8'h2A, 2);
      wait_cyc(30);

      // Short low glitch on ps2_clk with data low must not start a frame.
      ps2_data = 1'b0;
      wait_cyc(5);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(5);
      ps2_data = 1'b1;
      wait_cyc(TOUT + 100);
      check("glitch_no_event_data", 32'(data), 32'(last_good));

      // Timeout after start + 5 data bits.
      send_bits(8'h33, 1'b0, 1'b1, 6);
      sb.push_back('{1'b1, last_good, last_fall_cyc + 2 + FLEN + 1 + TOUT});
      wait_cyc(TOUT + 100);
      send_frame(8'h5A, 0);
      wait_cyc(30);

      // One-cycle reset after the 4th data bit.
      send_bits(8'h77, odd_par(8'h77), 1'b1, 5);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wait_cyc(2);
      check("reset_mid_frame_data", 32'(data), 32'h00);
      check("reset_mid_frame_valid", 32'(valid), 32'h0);
      last_good = 8'h00;
      wait_cyc(30);
      send_frame(8'h29, 0);

      // Random back-to-back frames with random bit timing and faults.
      for (int i = 0; i < 20; i++) begin
         half = $urandom_range(14, 30);
         b    = 8'($urandom);
         r    = $urandom_range(0, 5);
         send_frame(b, (r < 2) ? r + 1 : 0);
      end

      for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
      wait_cyc(5);
      check("scoreboard_drained", 32'(sb.size()), 32'h0);
      check("final_data", 32'(data), 32'(last_good));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synchronized samples required before a filtered PS/2 line changes state.
REQ-002 Parameter TIMEOUT, default 100000: maximum clk cycles between filtered ps2_clk falling edges inside a frame.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk  input  1  asynchronous PS/2 clock line; idle high.
REQ-006 ps2_data  input  1  asynchronous PS/2 data line; idle high.
REQ-007 data  output  8  last correctly received scan-code byte.
REQ-008 valid  output  1  one-cycle pulse; data holds a new byte.
REQ-009 error  output  1  one-cycle pulse; a frame was discarded.

Function
REQ-010 Each PS/2 line SHALL pass through a 2-flop synchronizer, then a filter.
- The filter output changes only after FILTER_LEN consecutive equal samples that differ from the current output.
REQ-011 A bit SHALL be sampled from filtered ps2_data on the cycle after filtered ps2_clk changes 1->0. This cycle is called a falling edge below.
REQ-012 Frame format: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1. Total 11 bits.
REQ-013 FSM states: IDLE, DATA, PARITY, STOP.
- IDLE -> DATA on a falling edge sampling 0.
- DATA -> PARITY after the 8th data bit.
- PARITY -> STOP on the next falling edge.
- STOP -> IDLE on the next falling edge.
REQ-014 A falling edge in IDLE that samples 1 SHALL be ignored: remain in IDLE, no error.
REQ-015 Data bits SHALL be shifted into an 8-bit register. A 4-bit counter SHALL count bits 0..7 and clear on entry to DATA.
REQ-016 On the stop edge, if parity is odd over the 9 bits and stop=1, then on the next cycle:
- data SHALL update;
- valid SHALL pulse for exactly 1 cycle.
REQ-017 On the stop edge, if parity is even or stop=0, then on the next cycle:
- error SHALL pulse for 1 cycle;
- data SHALL remain unchanged.
REQ-018 valid and error SHALL never be asserted together.
REQ-019 Outside IDLE, a cycle counter ($clog2(TIMEOUT+1) bits) SHALL clear on every falling edge.
- When it reaches TIMEOUT, the FSM SHALL return to IDLE and error SHALL pulse once.
- The partial byte SHALL be discarded.
REQ-020 The timeout counter SHALL hold at 0 in IDLE and SHALL not wrap.
REQ-021 Timeout and a falling edge in the same cycle: the edge wins and the counter clears.
REQ-022 Back-to-back frames SHALL be accepted with no dead time beyond the stop bit.
REQ-023 valid, error and data SHALL be registered outputs with no combinational path from the inputs.

Reset
REQ-024 While reset is high, the following SHALL be forced:
- state to IDLE;
- data to 8'h00, valid to 0, error to 0;
- shift register, bit counter and timeout counter to 0;
- synchronizer flops and filter outputs to 1;
- filter counters to 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no valid or error pulse, during reset or after it.
REQ-026 After reset deasserts, a frame SHALL be accepted only once the filtered ps2_clk has been seen high.

Structure
REQ-027 Package ps2_pkg SHALL hold:
- the FSM state enum;
- constants FRAME_DATA_BITS=8, START_BIT=0, STOP_BIT=1.
REQ-028 A sub-module ps2_line_filter (synchronizer plus filter, parameter FILTER_LEN) SHALL be instantiated twice, once for ps2_clk and once for ps2_data.

Verification
REQ-029 Send 8'h1C with parity 0 and stop 1 -> data=8'h1C; valid high for exactly 1 cycle; error stays 0.
REQ-030 Send 8'hE0, then immediately 8'hF0 (parity 1), then 8'h1C -> three valid pulses in order with data E0, F0, 1C.
REQ-031 Send 8'h1C with parity 1 -> error for 1 cycle; no valid; data keeps its previous value.
REQ-032 Send 8'h2A with stop bit 0 -> error pulse. Then inject a 3-cycle low glitch on ps2_clk (FILTER_LEN=8) -> no bit sampled.
REQ-033 Stop clocking after 5 data bits (TIMEOUT=1000) -> error exactly 1000 cycles after the last edge. A following frame 8'h5A -> valid with data=8'h5A.
REQ-034 Assert reset for 1 cycle after the 4th data bit -> no valid and no error. data=8'h00. The next full frame 8'h29 is received correctly.
